// File: rtl/top_decryption_pkg.sv
// Shared cipher definitions for the 5-round, 64-bit word cipher: widths, rotation amount,
// rotate helpers and the input lane permutation used by the receive side.
package top_decryption_pkg;

    localparam int WORD_W     = 16;
    localparam int NUM_STAGES = 5;
    localparam int NUM_LANES  = 4;
    localparam int DATA_W     = NUM_LANES * WORD_W;
    localparam int CTRL_W     = 8;
    localparam int KEY_W      = NUM_STAGES * WORD_W;
    localparam int ROT_AMT    = 3;

    // Which 16-bit lane of the incoming ciphertext feeds each decrypt sub-word
    localparam int PERM_D0 = 1;
    localparam int PERM_D1 = 0;
    localparam int PERM_D2 = 3;
    localparam int PERM_D3 = 2;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [DATA_W-1:0] data_t;

    function automatic word_t rotl16(input word_t x);
        return (x << ROT_AMT) | (x >> (WORD_W - ROT_AMT));
    endfunction

    function automatic word_t rotr16(input word_t x);
        return (x >> ROT_AMT) | (x << (WORD_W - ROT_AMT));
    endfunction

    function automatic data_t unpermute(input data_t c);
        return {c[PERM_D3*WORD_W +: WORD_W], c[PERM_D2*WORD_W +: WORD_W],
                c[PERM_D1*WORD_W +: WORD_W], c[PERM_D0*WORD_W +: WORD_W]};
    endfunction

endpackage

// File: rtl/top_decryption_stage.sv
// One decrypt round with its data/ctrl/valid registers; all registers advance only on adv.
// DECRYPT_CTRL_BYPASS_EN: words with non-zero ctrl pass through this round untouched.
module single_stage_decryption
    import top_decryption_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              adv,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [WORD_W-1:0] round_key,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic [DATA_W-1:0] round_data;
    logic [DATA_W-1:0] data_d, data_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic              valid_d, valid_q;

    // Inverse of the encrypt round: rotate right first, then remove the key
    always_comb begin
        round_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            round_data[i*WORD_W +: WORD_W] = rotr16(in_data[i*WORD_W +: WORD_W]) ^ round_key;
        end
    end

    always_comb begin
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (adv) begin
            valid_d = in_valid;
            ctrl_d  = in_ctrl;
            data_d  = round_data;
`ifdef DECRYPT_CTRL_BYPASS_EN
            if (in_ctrl != '0) begin
                data_d = in_data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ctrl  = ctrl_q;

endmodule

// File: rtl/top_decryption.sv
// Receive-side 5-stage decrypt pipeline with rdy/wr handshake; out_rdy backpressure stalls every stage.
// DECRYPT_CTRL_BYPASS_EN: header words (in_ctrl != 0) travel through unpermuted and undecrypted.
module top_decryption
    import top_decryption_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_wr,
    output logic              in_rdy,
    input  logic [KEY_W-1:0]  key,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_wr,
    input  logic              out_rdy,
    output logic              idle
);

    logic                  adv;
    logic [DATA_W-1:0]     head_data;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [DATA_W-1:0]     stage_data [NUM_STAGES];
    logic [CTRL_W-1:0]     stage_ctrl [NUM_STAGES];

    assign adv    = !stage_valid[NUM_STAGES-1] | out_rdy;
    assign in_rdy = adv;

    always_comb begin
        head_data = unpermute(in_data);
`ifdef DECRYPT_CTRL_BYPASS_EN
        if (in_ctrl != '0) begin
            head_data = in_data;
        end
`endif
    end

    // Decrypt stage s undoes encrypt round NUM_STAGES-1-s, so keys are taken low slice first
    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        logic              sin_valid;
        logic [DATA_W-1:0] sin_data;
        logic [CTRL_W-1:0] sin_ctrl;

        if (s == 0) begin : g_head
            assign sin_valid = in_wr;
            assign sin_data  = head_data;
            assign sin_ctrl  = in_ctrl;
        end else begin : g_link
            assign sin_valid = stage_valid[s-1];
            assign sin_data  = stage_data[s-1];
            assign sin_ctrl  = stage_ctrl[s-1];
        end

        single_stage_decryption u_stage (
            .clk       (clk),
            .reset     (reset),
            .adv       (adv),
            .in_valid  (sin_valid),
            .in_data   (sin_data),
            .in_ctrl   (sin_ctrl),
            .round_key (key[s*WORD_W +: WORD_W]),
            .out_valid (stage_valid[s]),
            .out_data  (stage_data[s]),
            .out_ctrl  (stage_ctrl[s])
        );
    end

    assign out_wr   = stage_valid[NUM_STAGES-1];
    assign out_data = stage_data[NUM_STAGES-1];
    assign out_ctrl = stage_ctrl[NUM_STAGES-1];
    assign idle     = ~|stage_valid;

endmodule

// File: tb/tb_top_decryption.sv
// Self-checking bench for top_decryption: directed vector table, encrypt/decrypt round trip,
// backpressure, mid-flight reset; expectations follow DECRYPT_CTRL_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_top_decryption;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [79:0] key;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        idle;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
    } sb_entry_t;

    typedef struct {
        logic [79:0] key;
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic [63:0] expected;
    } vector_t;

    sb_entry_t sb_q[$];
    vector_t   vectors[6];
    int        num_checks = 0;
    int        num_fail   = 0;
    int        cycle_cnt  = 0;

    top_decryption dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .in_rdy   (in_rdy),
        .key      (key),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .out_rdy  (out_rdy),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    function automatic logic [63:0] encrypt_model(input logic [63:0] pt, input logic [79:0] k);
        logic [15:0] e [4];
        logic [15:0] rk;
        for (int i = 0; i < 4; i++) e[i] = pt[16*i +: 16];
        for (int r = 0; r < 5; r++) begin
            rk = k[79-16*r -: 16];
            for (int i = 0; i < 4; i++) begin
                e[i] = e[i] ^ rk;
                e[i] = {e[i][12:0], e[i][15:13]};
            end
        end
        return {e[2], e[3], e[0], e[1]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard: every completed output transfer must match the oldest accepted word
    always @(negedge clk) begin
        if (!reset && out_wr && out_rdy) begin
            if (sb_q.size() == 0) begin
                num_checks++;
                num_fail++;
                $display("[TB] FAIL unexpected_output: got word %h with empty scoreboard, expected none", out_data);
            end else begin
                sb_entry_t e;
                e = sb_q.pop_front();
                checkOutput("out_data", out_data, e.data);
                checkOutput("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] data, input logic [7:0] ctrl, input logic [63:0] exp_data);
        bit accepted = 1'b0;
        in_data = data;
        in_ctrl = ctrl;
        in_wr   = 1'b1;
        for (int w = 0; w < 60 && !accepted; w++) begin
            @(negedge clk);
            if (in_rdy) accepted = 1'b1;
        end
        if (accepted) begin
            sb_q.push_back('{data: exp_data, ctrl: ctrl});
        end else begin
            num_checks++;
            num_fail++;
            $display("[TB] FAIL accept_timeout: got in_rdy=0 for 60 cycles, expected acceptance");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string name);
        bit drained = 1'b0;
        for (int w = 0; w < 300 && !drained; w++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && idle) drained = 1'b1;
        end
        checkOutput(name, 64'(sb_q.size()), 64'd0);
        checkOutput({name, "_idle"}, 64'(idle), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        int          start_cycle;
        logic [63:0] pt;
        logic [63:0] ct;
        logic [7:0]  ctl;
        int unsigned r;

        vectors[0] = '{key: 80'h0, data: 64'h0000_0000_0000_0008, ctrl: 8'h00, expected: 64'h0000_0000_0010_0000};
        vectors[1] = '{key: 80'h0, data: 64'h8000_0001_4000_0002, ctrl: 8'h00, expected: 64'h0002_0001_0004_8000};
        vectors[2] = '{key: 80'hFFFF_FFFF_FFFF_FFFF_FFFF, data: 64'h0000_0000_0000_0008, ctrl: 8'h00,
                       expected: 64'hFFFF_FFFF_FFEF_FFFF};
        vectors[3] = '{key: 80'h1234_0000_0000_0000_0000, data: 64'h0, ctrl: 8'h00, expected: 64'h1234_1234_1234_1234};
        vectors[4] = '{key: 80'h0000_0000_0000_0000_0001, data: 64'h0, ctrl: 8'h00, expected: 64'h0010_0010_0010_0010};
`ifdef DECRYPT_CTRL_BYPASS_EN
        vectors[5] = '{key: 80'h0, data: 64'hDEAD_BEEF_0123_4567, ctrl: 8'hFF, expected: 64'hDEAD_BEEF_0123_4567};
`else
        vectors[5] = '{key: 80'h0, data: 64'hDEAD_BEEF_0123_4567, ctrl: 8'hFF, expected: 64'h7DDF_BD5B_8ACE_0246};
`endif

        reset   = 1'b1;
        in_data = '0;
        in_ctrl = '0;
        in_wr   = 1'b0;
        key     = '0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_wr", 64'(out_wr), 64'd0);
        checkOutput("reset_out_data", out_data, 64'd0);
        checkOutput("reset_out_ctrl", 64'(out_ctrl), 64'd0);
        checkOutput("reset_idle", 64'(idle), 64'd1);
        checkOutput("reset_in_rdy", 64'(in_rdy), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] single word latency");
        applyStimulus(64'h0000_0000_0000_0008, 8'h00, 64'h0000_0000_0010_0000);
        in_wr = 1'b0;
        lat = 0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            lat++;
            if (out_wr) break;
        end
        checkOutput("latency", 64'(lat), 64'd5);
        @(negedge clk);
        checkOutput("out_wr_single_cycle", 64'(out_wr), 64'd0);
        waitDrain("latency_drain");

        $display("[TB] vector table");
        foreach (vectors[i]) begin
            key = vectors[i].key;
            applyStimulus(vectors[i].data, vectors[i].ctrl, vectors[i].expected);
            in_wr = 1'b0;
            waitDrain("vector_drain");
        end

        $display("[TB] round trip, 1000 words");
        r   = $urandom;
        key = {$urandom, $urandom, r[15:0]};
        start_cycle = cycle_cnt;
        for (int n = 0; n < 1000; n++) begin
            pt = {$urandom, $urandom};
            r  = $urandom;
            ctl = (r[9:8] == 2'b00) ? r[7:0] : 8'h00;
            ct = encrypt_model(pt, key);
`ifdef DECRYPT_CTRL_BYPASS_EN
            applyStimulus(ct, ctl, (ctl != 8'h00) ? ct : pt);
`else
            applyStimulus(ct, ctl, pt);
`endif
        end
        checkOutput("throughput_cycles", 64'(cycle_cnt - start_cycle), 64'd1000);
        in_wr = 1'b0;
        waitDrain("roundtrip_drain");

        $display("[TB] backpressure with in_wr held");
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    pt = {$urandom, $urandom};
                    applyStimulus(encrypt_model(pt, key), 8'h00, pt);
                end
                in_wr = 1'b0;
            end
            begin
                bit seen = 1'b0;
                for (int w = 0; w < 30 && !seen; w++) begin
                    @(posedge clk);
                    #1;
                    if (out_wr) seen = 1'b1;
                end
                checkOutput("stall_out_wr_seen", 64'(seen), 64'd1);
                out_rdy = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    checkOutput("stall_in_rdy", 64'(in_rdy), 64'd0);
                    checkOutput("stall_out_wr", 64'(out_wr), 64'd1);
                    if (sb_q.size() > 0) checkOutput("stall_out_data_held", out_data, sb_q[0].data);
                end
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        waitDrain("backpressure_drain");

        $display("[TB] reset with words in flight");
        for (int n = 0; n < 3; n++) begin
            applyStimulus(64'h1111_2222_3333_0000 + 64'(n), 8'h00, 64'h0);
        end
        in_wr = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
        @(negedge clk);
        checkOutput("flush_out_wr", 64'(out_wr), 64'd0);
        checkOutput("flush_idle", 64'(idle), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("flush_idle_later", 64'(idle), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
